arp_resolver: RTL and testbench

- Servicing end of the IP transmit path's ARP handshake: accepts `arp_request_*` from the IP TX controller and returns `arp_response_*`.
- Handles broadcast destinations and off-subnet routing, so the requester only sees a MAC or an error.
- Looks up a small direct-mapped IP→MAC cache.
- On a cache miss, issues ARP query requests to the ARP frame transmitter, then waits for the learned mapping on the cache write port. Retries with a timeout.

---
 rtl/arp_resolver_if.sv | 44 ++++
 rtl/arp_resolver.sv | 214 +++++++++++++++++++++
 tb/tb_arp_resolver.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_resolver_if.sv
// -----------------------------------------------------------------------------
// arp_resolver_if
// Bundles every handshake and strobe channel of the ARP resolver.
//   arp_request_*  : lookup request from the IP TX controller
//   arp_response_* : resolved MAC (or error) back to the IP TX controller
//   arp_query_*    : who-has query towards the ARP frame transmitter
//   cache_wr_*     : learned IP->MAC mapping from the ARP receiver (strobe)
//   cache_clear    : invalidate every cache entry
// Modports:
//   slave  : the resolver itself
//   master : the surrounding environment (IP TX, ARP TX, ARP RX)
// -----------------------------------------------------------------------------
interface arp_resolver_if;
   logic        arp_request_valid;
   logic        arp_request_ready;
   logic [31:0] arp_request_ip;
   logic        arp_response_valid;
   logic        arp_response_ready;
   logic        arp_response_error;
   logic [47:0] arp_response_mac;
   logic        arp_query_valid;
   logic        arp_query_ready;
   logic [31:0] arp_query_ip;
   logic        cache_wr_valid;
   logic [31:0] cache_wr_ip;
   logic [47:0] cache_wr_mac;
   logic        cache_clear;

   modport slave (
      input  arp_request_valid, arp_request_ip, arp_response_ready,
             arp_query_ready, cache_wr_valid, cache_wr_ip, cache_wr_mac,
             cache_clear,
      output arp_request_ready, arp_response_valid, arp_response_error,
             arp_response_mac, arp_query_valid, arp_query_ip
   );

   modport master (
      output arp_request_valid, arp_request_ip, arp_response_ready,
             arp_query_ready, cache_wr_valid, cache_wr_ip, cache_wr_mac,
             cache_clear,
      input  arp_request_ready, arp_response_valid, arp_response_error,
             arp_response_mac, arp_query_valid, arp_query_ip
   );
endinterface

// File: rtl/arp_resolver.sv
// -----------------------------------------------------------------------------
// arp_resolver
// Resolves a destination IP to a MAC for the IP transmit path. Broadcast
// destinations answer immediately with FF:FF:FF:FF:FF:FF, off-subnet
// destinations are resolved through the gateway, everything else goes through
// a small direct-mapped IP->MAC cache. On a miss a who-has query is issued and
// the resolver waits for the learned mapping on the cache write port, retrying
// on timeout and finally answering with an error.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   bus          arp_resolver_if.slave (request/response/query/cache channels)
//   local_ip, gateway_ip, subnet_mask : configuration, sampled at request accept
//   stat_hit, stat_miss, stat_fail    : 16-bit saturating counters, present only
//                                       when ARP_RESOLVER_STATS_EN is defined
// -----------------------------------------------------------------------------
module arp_resolver #(
   parameter int CACHE_ADDR_WIDTH = 2,
   parameter int RETRY_COUNT      = 4,
   parameter int RETRY_INTERVAL   = 125000
) (
   input  logic                 clk,
   input  logic                 rst,
   arp_resolver_if.slave        bus,
   input  logic [31:0]          local_ip,
   input  logic [31:0]          gateway_ip,
   input  logic [31:0]          subnet_mask
`ifdef ARP_RESOLVER_STATS_EN
   ,
   output logic [15:0]          stat_hit,
   output logic [15:0]          stat_miss,
   output logic [15:0]          stat_fail
`endif
);

   localparam int ENTRIES = 1 << CACHE_ADDR_WIDTH;
   localparam int RW      = (RETRY_COUNT > 1) ? $clog2(RETRY_COUNT) : 1;
   localparam int TW      = (RETRY_INTERVAL > 1) ? $clog2(RETRY_INTERVAL) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_QUERY, S_WAIT, S_RESP
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_target, w_target_nxt;
   logic [47:0]       r_mac, w_mac_nxt;
   logic              r_error, w_error_nxt;
   logic [RW-1:0]     r_retries, w_retries_nxt;
   logic [TW-1:0]     r_timer, w_timer_nxt;

   logic [ENTRIES-1:0] r_valid;
   logic [31:0]        r_tag [ENTRIES];
   logic [47:0]        r_data [ENTRIES];

   logic [CACHE_ADDR_WIDTH-1:0] w_rd_idx, w_wr_idx;
   logic [31:0] w_net_diff;
   logic        w_is_bcast, w_off_subnet, w_wr_match, w_entry_hit;
   logic        w_hit, w_miss, w_fail;

   assign w_rd_idx = r_target[CACHE_ADDR_WIDTH-1:0];
   assign w_wr_idx = bus.cache_wr_ip[CACHE_ADDR_WIDTH-1:0];

   // Subnet-directed broadcast: same network and all host bits set.
   assign w_net_diff   = (bus.arp_request_ip ^ local_ip) & subnet_mask;
   assign w_off_subnet = (w_net_diff != '0);
   assign w_is_bcast   = (bus.arp_request_ip == '1) ||
                         (!w_off_subnet && ((bus.arp_request_ip | subnet_mask) == '1));

   // A learned mapping arriving this cycle for our target; also serves as the
   // LOOKUP bypass so a same-cycle write is not missed.
   assign w_wr_match  = bus.cache_wr_valid && (bus.cache_wr_ip == r_target);
   assign w_entry_hit = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == r_target);

   // Handshake outputs are pure state decodes.
   assign bus.arp_request_ready  = (r_state == S_IDLE);
   assign bus.arp_response_valid = (r_state == S_RESP);
   assign bus.arp_query_valid    = (r_state == S_QUERY);
   assign bus.arp_response_mac   = r_mac;
   assign bus.arp_response_error = r_error;
   assign bus.arp_query_ip       = r_target;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_state_nxt   = r_state;
      w_target_nxt  = r_target;
      w_mac_nxt     = r_mac;
      w_error_nxt   = r_error;
      w_retries_nxt = r_retries;
      w_timer_nxt   = r_timer;
      w_hit         = 1'b0;
      w_miss        = 1'b0;
      w_fail        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.arp_request_valid) begin
               if (w_is_bcast) begin
                  w_state_nxt = S_RESP;
                  w_mac_nxt   = '1;
                  w_error_nxt = 1'b0;
               end else begin
                  w_state_nxt  = S_LOOKUP;
                  w_target_nxt = w_off_subnet ? gateway_ip : bus.arp_request_ip;
               end
            end
         end
         S_LOOKUP: begin
            if (w_wr_match) begin
               w_state_nxt = S_RESP;
               w_mac_nxt   = bus.cache_wr_mac;
               w_error_nxt = 1'b0;
               w_hit       = 1'b1;
            end else if (w_entry_hit) begin
               w_state_nxt = S_RESP;
               w_mac_nxt   = r_data[w_rd_idx];
               w_error_nxt = 1'b0;
               w_hit       = 1'b1;
            end else begin
               w_state_nxt   = S_QUERY;
               w_retries_nxt = RW'(RETRY_COUNT - 1);
               w_miss        = 1'b1;
            end
         end
         S_QUERY: begin
            if (bus.arp_query_ready) begin
               w_state_nxt = S_WAIT;
               w_timer_nxt = TW'(RETRY_INTERVAL - 1);
            end
         end
         S_WAIT: begin
            if (w_wr_match) begin
               w_state_nxt = S_RESP;
               w_mac_nxt   = bus.cache_wr_mac;
               w_error_nxt = 1'b0;
            end else if (r_timer == '0) begin
               if (r_retries == '0) begin
                  w_state_nxt = S_RESP;
                  w_mac_nxt   = '0;
                  w_error_nxt = 1'b1;
                  w_fail      = 1'b1;
               end else begin
                  w_state_nxt   = S_QUERY;
                  w_retries_nxt = r_retries - RW'(1);
               end
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         S_RESP: begin
            if (bus.arp_response_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_target  <= '0;
         r_mac     <= '0;
         r_error   <= 1'b0;
         r_retries <= '0;
         r_timer   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_target  <= w_target_nxt;
         r_mac     <= w_mac_nxt;
         r_error   <= w_error_nxt;
         r_retries <= w_retries_nxt;
         r_timer   <= w_timer_nxt;
      end
   end

   // Clear wins over a same-cycle write.
   always_ff @(posedge clk) begin
      if (!rst || bus.cache_clear) begin
         r_valid <= '0;
      end else if (bus.cache_wr_valid) begin
         r_valid[w_wr_idx] <= 1'b1;
      end
   end

   // NOTE: the tag/data arrays carry no reset; the valid bits alone decide
   // whether an entry is meaningful, so the arrays can map to plain storage.
   always_ff @(posedge clk) begin
      if (rst && bus.cache_wr_valid && !bus.cache_clear) begin
         r_tag[w_wr_idx]  <= bus.cache_wr_ip;
         r_data[w_wr_idx] <= bus.cache_wr_mac;
      end
   end

`ifdef ARP_RESOLVER_STATS_EN
   logic [15:0] r_stat_hit, r_stat_miss, r_stat_fail;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stat_hit  <= '0;
         r_stat_miss <= '0;
         r_stat_fail <= '0;
      end else begin
         if (w_hit  && (r_stat_hit  != '1)) r_stat_hit  <= r_stat_hit  + 16'd1;
         if (w_miss && (r_stat_miss != '1)) r_stat_miss <= r_stat_miss + 16'd1;
         if (w_fail && (r_stat_fail != '1)) r_stat_fail <= r_stat_fail + 16'd1;
      end
   end

   assign stat_hit  = r_stat_hit;
   assign stat_miss = r_stat_miss;
   assign stat_fail = r_stat_fail;
`endif

endmodule

// File: tb/tb_arp_resolver.sv
// -----------------------------------------------------------------------------
// tb_arp_resolver
// Directed bench for arp_resolver with RETRY_COUNT=2, RETRY_INTERVAL=16 and
// local 192.168.1.100/24, gateway 192.168.1.1. Inputs are driven 1 time unit
// after the rising edge; outputs are read at the same point, after the DUT's
// registers have settled.
// -----------------------------------------------------------------------------
module tb_arp_resolver;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] local_ip, gateway_ip, subnet_mask;

   arp_resolver_if bus ();

`ifdef ARP_RESOLVER_STATS_EN
   logic [15:0] stat_hit, stat_miss, stat_fail;
`endif

   arp_resolver #(
      .CACHE_ADDR_WIDTH (2),
      .RETRY_COUNT      (2),
      .RETRY_INTERVAL   (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .local_ip    (local_ip),
      .gateway_ip  (gateway_ip),
      .subnet_mask (subnet_mask)
`ifdef ARP_RESOLVER_STATS_EN
      ,
      .stat_hit    (stat_hit),
      .stat_miss   (stat_miss),
      .stat_fail   (stat_fail)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Query-channel monitor: cycle stamp of each query handshake.
   int          cyc = 0;
   int          q_count = 0;
   logic [31:0] q_last_ip = '0;
   int          q_cyc[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.arp_query_valid && bus.arp_query_ready) begin
         q_count++;
         q_last_ip = bus.arp_query_ip;
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return just after the accept edge.
   task automatic send(input logic [31:0] ip);
      int g;
      g = 0;
      bus.arp_request_ip    = ip;
      bus.arp_request_valid = 1'b1;
      while (!bus.arp_request_ready && g < 50) begin
         step();
         g++;
      end
      check("req_accepted", 64'(g < 50), 64'd1);
      step();
      bus.arp_request_valid = 1'b0;
   endtask

   // lat = number of edges from the accept edge to the first edge after which
   // arp_response_valid is visible (1 = directly after the accept edge).
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!bus.arp_response_valid && lat < 200) begin
         step();
         lat++;
      end
   endtask

   task automatic consume();
      bus.arp_response_ready = 1'b1;
      step();
      bus.arp_response_ready = 1'b0;
      check("resp_released", 64'(bus.arp_response_valid), 64'd0);
   endtask

   // Wait until a new query handshake has happened (state is then WAIT).
   task automatic wait_query(input int base);
      int g;
      g = 0;
      while (q_count == base && g < 100) begin
         step();
         g++;
      end
      check("query_seen", 64'(q_count == base + 1), 64'd1);
   endtask

   // Answer an outstanding query with a one-cycle cache write in WAIT.
   task automatic learn(input logic [31:0] ip, input logic [47:0] mac, input int base);
      wait_query(base);
      bus.cache_wr_ip    = ip;
      bus.cache_wr_mac   = mac;
      bus.cache_wr_valid = 1'b1;
      step();
      bus.cache_wr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      int base;
      int qi;

      local_ip                = 32'hC0A80164;
      gateway_ip              = 32'hC0A80101;
      subnet_mask             = 32'hFFFFFF00;
      rst                     = 1'b0;
      bus.arp_request_valid   = 1'b0;
      bus.arp_request_ip      = '0;
      bus.arp_response_ready  = 1'b0;
      bus.arp_query_ready     = 1'b1;
      bus.cache_wr_valid      = 1'b0;
      bus.cache_wr_ip         = '0;
      bus.cache_wr_mac        = '0;
      bus.cache_clear         = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) step();
      check("rst_resp_valid", 64'(bus.arp_response_valid), 64'd0);
      check("rst_query_valid", 64'(bus.arp_query_valid), 64'd0);
      check("rst_resp_mac", 64'(bus.arp_response_mac), 64'd0);
      rst = 1'b1;
      step();
      check("idle_ready", 64'(bus.arp_request_ready), 64'd1);

      // ---------------- broadcast ----------------
      base = q_count;
      send(32'hFFFFFFFF);
      wait_resp(lat);
      check("bcast_all_lat", 64'(lat), 64'd1);
      check("bcast_all_mac", 64'(bus.arp_response_mac), 64'hFFFF_FFFF_FFFF);
      check("bcast_all_err", 64'(bus.arp_response_error), 64'd0);
      consume();
      send(32'hC0A801FF);
      wait_resp(lat);
      check("bcast_net_lat", 64'(lat), 64'd1);
      check("bcast_net_mac", 64'(bus.arp_response_mac), 64'hFFFF_FFFF_FFFF);
      check("bcast_net_err", 64'(bus.arp_response_error), 64'd0);
      consume();
      check("bcast_no_query", 64'(q_count - base), 64'd0);

      // ---------------- miss then learn ----------------
      base = q_count;
      send(32'hC0A80105);
      learn(32'hC0A80105, 48'h020000000005, base);
      check("miss_query_ip", 64'(q_last_ip), 64'hC0A80105);
      wait_resp(lat);
      check("learn_mac", 64'(bus.arp_response_mac), 64'h020000000005);
      check("learn_err", 64'(bus.arp_response_error), 64'd0);
      consume();

      base = q_count;
      send(32'hC0A80105);
      wait_resp(lat);
      check("hit_lat", 64'(lat), 64'd2);
      check("hit_mac", 64'(bus.arp_response_mac), 64'h020000000005);
      consume();
      check("hit_no_query", 64'(q_count - base), 64'd0);

      // ---------------- off-subnet via gateway ----------------
      base = q_count;
      send(32'h08080808);
      learn(32'hC0A80101, 48'h020000000101, base);
      check("gw_query_ip", 64'(q_last_ip), 64'hC0A80101);
      wait_resp(lat);
      check("gw_mac", 64'(bus.arp_response_mac), 64'h020000000101);
      consume();

      base = q_count;
      send(32'h01010101);
      wait_resp(lat);
      check("gw_hit_lat", 64'(lat), 64'd2);
      check("gw_hit_mac", 64'(bus.arp_response_mac), 64'h020000000101);
      consume();
      check("gw_hit_no_query", 64'(q_count - base), 64'd0);

      // ---------------- timeout ----------------
      // Accept A, LOOKUP, QUERY handshake at A+2, 16 WAIT cycles, QUERY again
      // (handshake 17 edges after the first), 16 WAIT cycles, RESP after A+35.
      base = q_count;
      qi   = q_cyc.size();
      send(32'hC0A80109);
      wait_resp(lat);
      check("tmo_lat", 64'(lat), 64'd36);
      check("tmo_err", 64'(bus.arp_response_error), 64'd1);
      check("tmo_mac", 64'(bus.arp_response_mac), 64'd0);
      check("tmo_queries", 64'(q_count - base), 64'd2);
      if (q_cyc.size() >= qi + 2)
         check("tmo_query_gap", 64'(q_cyc[qi+1] - q_cyc[qi]), 64'd17);
      else
         check("tmo_query_gap", 64'(q_cyc.size() - qi), 64'd2);
      consume();

      // ---------------- collision ----------------
      base = q_count;
      send(32'hC0A80105);
      learn(32'hC0A80105, 48'h020000000005, base);
      wait_resp(lat);
      consume();
      base = q_count;
      send(32'hC0A80109);
      learn(32'hC0A80109, 48'h020000000009, base);
      wait_resp(lat);
      check("coll_learn9_mac", 64'(bus.arp_response_mac), 64'h020000000009);
      consume();
      base = q_count;
      send(32'hC0A80105);
      learn(32'hC0A80105, 48'h020000000005, base);
      check("coll_query_ip", 64'(q_last_ip), 64'hC0A80105);
      wait_resp(lat);
      consume();

      // ---------------- clear with simultaneous write ----------------
      bus.cache_wr_ip    = 32'hC0A80102;
      bus.cache_wr_mac   = 48'h020000000002;
      bus.cache_wr_valid = 1'b1;
      bus.cache_clear    = 1'b1;
      step();
      bus.cache_wr_valid = 1'b0;
      bus.cache_clear    = 1'b0;
      base = q_count;
      send(32'hC0A80102);
      learn(32'hC0A80102, 48'h020000000002, base);
      wait_resp(lat);
      consume();
      base = q_count;
      send(32'hC0A80105);
      learn(32'hC0A80105, 48'h020000000005, base);
      wait_resp(lat);
      consume();

      // ---------------- reset mid-operation ----------------
      base = q_count;
      send(32'hC0A80107);
      wait_query(base);
      rst = 1'b0;
      step();
      check("midrst_resp_valid", 64'(bus.arp_response_valid), 64'd0);
      check("midrst_query_valid", 64'(bus.arp_query_valid), 64'd0);
      check("midrst_resp_mac", 64'(bus.arp_response_mac), 64'd0);
      check("midrst_resp_err", 64'(bus.arp_response_error), 64'd0);
      check("midrst_query_ip", 64'(bus.arp_query_ip), 64'd0);
      rst = 1'b1;
      step();
      base = q_count;
      send(32'hC0A80107);
      learn(32'hC0A80107, 48'h020000000007, base);
      wait_resp(lat);
      check("postrst_mac", 64'(bus.arp_response_mac), 64'h020000000007);
      consume();

      // C0A80102 was cached before the reset; it must miss now.
      base = q_count;
      send(32'hC0A80102);
      learn(32'hC0A80102, 48'h020000000002, base);
      wait_resp(lat);
      check("bp_valid0", 64'(bus.arp_response_valid), 64'd1);

      // ---------------- response backpressure ----------------
      for (int i = 1; i <= 5; i++) begin
         step();
         check("bp_hold_valid", 64'(bus.arp_response_valid), 64'd1);
         check("bp_hold_mac", 64'(bus.arp_response_mac), 64'h020000000002);
         check("bp_hold_err", 64'(bus.arp_response_error), 64'd0);
      end
      consume();
      check("bp_back_idle", 64'(bus.arp_request_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
